// File: rtl/jt89_regs.sv
// jt89_regs: CPU write decoder and register file for the SN76489-compatible PSG.
// Turns latch/data bytes into tone periods, attenuations and noise control.
// Also produces the noise LFSR clear pulse and the READY handshake.
module jt89_regs #(
  parameter int BUSY_CNT = 32,
  parameter int CW       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       clr
);

  logic [9:0]    tone_q [3];
  logic [9:0]    tone_d [3];
  logic [3:0]    vol_q  [4];
  logic [3:0]    vol_d  [4];
  logic [2:0]    ctrl3_q, ctrl3_d;
  logic [1:0]    ch_q, ch_d;
  logic          type_q, type_d;
  logic          clr_q, clr_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_l_q;

  logic          wr_evt;
  logic [1:0]    sel_ch;
  logic          sel_type;

  // A write is the first clk that sees wr_n low after it was high; a held strobe
  // or a strobe that fell with cs_n high never becomes an event later.
  assign wr_evt   = wr_l_q & ~wr_n & ~cs_n & ready_q;
  assign sel_ch   = din[7] ? din[6:5] : ch_q;
  assign sel_type = din[7] ? din[4]   : type_q;

  // Next-state decode of the write byte and the busy countdown.
  always_comb begin
    tone_d  = tone_q;
    vol_d   = vol_q;
    ctrl3_d = ctrl3_q;
    ch_d    = ch_q;
    type_d  = type_q;
    clr_d   = 1'b0;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    if (wr_evt) begin
      if (din[7]) begin
        ch_d   = din[6:5];
        type_d = din[4];
      end
      if (sel_type) begin
        vol_d[sel_ch] = din[3:0];
      end else if (sel_ch == 2'd3) begin
        ctrl3_d = din[2:0];
        clr_d   = 1'b1;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (sel_ch == 2'(k)) begin
            // Latch byte carries the low nibble, data byte the upper six bits.
            if (din[7]) tone_d[k][3:0] = din[3:0];
            else        tone_d[k][9:4] = din[5:0];
          end
        end
      end
      if (BUSY_CNT > 0) begin
        ready_d = 1'b0;
        cnt_d   = CW'(BUSY_CNT);
      end
    end else if (!ready_q && clk_en) begin
      // READY rises on the same tick that takes the counter to zero.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) ready_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_q  <= '{default: '0};
      vol_q   <= '{default: 4'hF};
      ctrl3_q <= '0;
      ch_q    <= '0;
      type_q  <= 1'b0;
      clr_q   <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
      wr_l_q  <= 1'b1;
    end else begin
      tone_q  <= tone_d;
      vol_q   <= vol_d;
      ctrl3_q <= ctrl3_d;
      ch_q    <= ch_d;
      type_q  <= type_d;
      clr_q   <= clr_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      wr_l_q  <= wr_n;
    end
  end

  assign ready = ready_q;
  assign tone0 = tone_q[0];
  assign tone1 = tone_q[1];
  assign tone2 = tone_q[2];
  assign vol0  = vol_q[0];
  assign vol1  = vol_q[1];
  assign vol2  = vol_q[2];
  assign vol3  = vol_q[3];
  assign ctrl3 = ctrl3_q;
  assign clr   = clr_q;

endmodule

// File: tb/tb_jt89_regs.sv
// tb_jt89_regs: scoreboard bench for jt89_regs. Two instances (no busy and
// 32-tick busy) share one stimulus stream; a register-level reference model
// predicts every cycle's outputs into a queue that a monitor drains.
module tb_jt89_regs;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, cs_n, wr_n;
  logic [7:0] din;

  typedef struct packed {
    logic [9:0] t0, t1, t2;
    logic [3:0] v0, v1, v2, v3;
    logic [2:0] c;
    logic       clr;
    logic       rdy;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic       rdy_a, clr_a, rdy_b, clr_b;
  logic [9:0] t0_a, t1_a, t2_a, t0_b, t1_b, t2_b;
  logic [3:0] v0_a, v1_a, v2_a, v3_a, v0_b, v1_b, v2_b, v3_b;
  logic [2:0] c_a, c_b;

  jt89_regs #(.BUSY_CNT(0), .CW(6)) u_nobusy (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n), .din(din),
    .ready(rdy_a), .tone0(t0_a), .tone1(t1_a), .tone2(t2_a),
    .vol0(v0_a), .vol1(v1_a), .vol2(v2_a), .vol3(v3_a), .ctrl3(c_a), .clr(clr_a));

  jt89_regs #(.BUSY_CNT(32), .CW(6)) u_busy (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n), .din(din),
    .ready(rdy_b), .tone0(t0_b), .tone1(t1_b), .tone2(t2_b),
    .vol0(v0_b), .vol1(v1_b), .vol2(v2_b), .vol3(v3_b), .ctrl3(c_b), .clr(clr_b));

  always #5 clk = ~clk;

  // Reference model: plain register arrays plus "busy ticks left" per instance.
  localparam int BUSY [2] = '{0, 32};
  int m_tone [2][3];
  int m_vol  [2][4];
  int m_ctrl [2];
  int m_clr  [2];
  int m_left [2];
  int m_ch   [2];
  int m_ty   [2];
  int m_wl   [2];

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ncyc  = 0;
  int   ce_per = 1;

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) m_tone[i][k] = 0;
        for (int k = 0; k < 4; k++) m_vol[i][k] = 15;
        m_ctrl[i] = 0; m_clr[i] = 0; m_left[i] = 0;
        m_ch[i] = 0; m_ty[i] = 0; m_wl[i] = 1;
      end else begin
        bit evt;
        evt = (m_wl[i] == 1) && !wr_n && !cs_n && (m_left[i] == 0);
        m_clr[i] = 0;
        if (evt) begin
          if (din[7]) begin
            m_ch[i] = int'(din[6:5]);
            m_ty[i] = int'(din[4]);
          end
          if (m_ty[i] == 1)
            m_vol[i][m_ch[i]] = int'(din[3:0]);
          else if (m_ch[i] == 3) begin
            m_ctrl[i] = int'(din[2:0]);
            m_clr[i]  = 1;
          end else if (din[7])
            m_tone[i][m_ch[i]] = (m_tone[i][m_ch[i]] / 16) * 16 + int'(din[3:0]);
          else
            m_tone[i][m_ch[i]] = int'(din[5:0]) * 16 + (m_tone[i][m_ch[i]] % 16);
          m_left[i] = BUSY[i];
        end else if (m_left[i] > 0 && clk_en) begin
          m_left[i] = m_left[i] - 1;
        end
        m_wl[i] = int'(wr_n);
      end
    end
  endtask

  function automatic obs_t model_obs(int i);
    obs_t o;
    o.t0 = 10'(m_tone[i][0]); o.t1 = 10'(m_tone[i][1]); o.t2 = 10'(m_tone[i][2]);
    o.v0 = 4'(m_vol[i][0]); o.v1 = 4'(m_vol[i][1]);
    o.v2 = 4'(m_vol[i][2]); o.v3 = 4'(m_vol[i][3]);
    o.c = 3'(m_ctrl[i]); o.clr = 1'(m_clr[i]); o.rdy = (m_left[i] == 0);
    return o;
  endfunction

  // One clock of stimulus: drive, predict the post-edge outputs, wait.
  task automatic cyc(bit r, bit cs, bit wr, logic [7:0] d);
    rst_n = r; cs_n = cs; wr_n = wr; din = d;
    clk_en = (ce_per == 0) ? ($urandom_range(0, 3) == 0) :
             (ce_per == 1) ? 1'b1 : (ncyc % ce_per == 0);
    model_step();
    q.push_back('{a: model_obs(0), b: model_obs(1)});
    ncyc++;
    @(negedge clk);
  endtask

  task automatic wr(logic [7:0] d);
    cyc(1, 0, 0, d);
    cyc(1, 0, 1, d);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 1, 8'h00);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, ncyc, act, expv);
    end
  endtask

  task automatic cmp_obs(string p, obs_t a, obs_t e);
    chk({p, ".tone0"}, 32'(a.t0), 32'(e.t0));
    chk({p, ".tone1"}, 32'(a.t1), 32'(e.t1));
    chk({p, ".tone2"}, 32'(a.t2), 32'(e.t2));
    chk({p, ".vol0"},  32'(a.v0), 32'(e.v0));
    chk({p, ".vol1"},  32'(a.v1), 32'(e.v1));
    chk({p, ".vol2"},  32'(a.v2), 32'(e.v2));
    chk({p, ".vol3"},  32'(a.v3), 32'(e.v3));
    chk({p, ".ctrl3"}, 32'(a.c),  32'(e.c));
    chk({p, ".clr"},   32'(a.clr), 32'(e.clr));
    chk({p, ".ready"}, 32'(a.rdy), 32'(e.rdy));
  endtask

  // Monitor: shortly after each edge, compare DUT outputs with the oldest prediction.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      obs_t a;
      e = q.pop_front();
      a = '{t0: t0_a, t1: t1_a, t2: t2_a, v0: v0_a, v1: v1_a, v2: v2_a, v3: v3_a,
            c: c_a, clr: clr_a, rdy: rdy_a};
      cmp_obs("nobusy", a, e.a);
      a = '{t0: t0_b, t1: t1_b, t2: t2_b, v0: v0_b, v1: v1_b, v2: v2_b, v3: v3_b,
            c: c_b, clr: clr_b, rdy: rdy_b};
      cmp_obs("busy", a, e.b);
    end
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; cs_n = 1'b1; wr_n = 1'b1; din = 8'h00;
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 8'h00);
    idle(2);
    // Tone, noise and volume writes, spaced so the busy instance is ready again.
    ce_per = 1;
    wr(8'h8E); idle(40); wr(8'h1F); idle(40);
    wr(8'hE5); idle(40); wr(8'h02); idle(40);
    wr(8'hD3); idle(40); wr(8'h7A); idle(40);
    // Back-to-back noise writes: each gets its own clr on the no-busy instance.
    wr(8'hE6); wr(8'h01); idle(40);
    // Busy window with clk_en every 16 clk; second write falls inside it.
    ce_per = 16;
    wr(8'h90); idle(60); wr(8'h9F); idle(560);
    ce_per = 1;
    // wr_n falls while cs_n is high, then cs_n drops with wr_n still low.
    cyc(1, 1, 0, 8'h95); cyc(1, 0, 0, 8'h95); cyc(1, 0, 1, 8'h95); idle(40);
    // Strobe held low for 10 clk gives one event only.
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 8'hB7);
    cyc(1, 0, 1, 8'h00); idle(40);
    // Reset in the middle of a busy window.
    ce_per = 16;
    wr(8'hC9); idle(30);
    cyc(0, 1, 1, 8'h00); idle(5);
    wr(8'h84); idle(40);
    // Randomised traffic, random clk_en and occasional reset.
    ce_per = 0;
    for (int k = 0; k < 4000; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) != 0, d);
    end
    idle(4);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
